// File: rtl/alu_pkg.sv
// Shared types for the logic-unit front end: loader FSM states and operation codes.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package alu_pkg;

  // Loader FSM states; the values are also shown on the debug LEDs
  typedef enum logic [1:0] {
    CARGA_A  = 2'd0,
    CARGA_B  = 2'd1,
    CARGA_OP = 2'd2,
    LISTO    = 2'd3
  } estado_t;

  // Operation codes understood by the logic unit
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOT = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5
  } op_t;

  // Highest code the logic unit defines; larger codes can be rejected at load time
  localparam logic [2:0] CODIGO_MAX = 3'd5;

endpackage

// File: rtl/detector_flanco.sv
// Synchronises an asynchronous, debounced button and emits a one-clock pulse on its rising edge.
// Latency: button rises before edge e1 -> pulso high between e2 and e3.
// Backpressure: none; holding the button high yields a single pulse.
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic pulso
);

  logic s1;
  logic s2;
  logic s3;

  // Three-flop chain: s1/s2 resolve metastability, s3 remembers the previous level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= boton;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulso = s2 & ~s3;

endmodule

// File: rtl/secuenciador_operandos.sv
// Loads operand 1, operand 2 and the op code from a shared switch bus, one value per button press.
// Latency: register written on the third clock edge after cargar rises; outputs straight from flops.
// Backpressure: none; a press is consumed immediately. Optional macro SECUENCIADOR_VALIDA_CODIGO_EN rejects op codes above CODIGO_MAX.
module secuenciador_operandos
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] entrada,
  input  logic         cargar,
  input  logic         limpiar,
  output logic [N-1:0] operador1,
  output logic [N-1:0] operador2,
  output logic [2:0]   ALUControl,
  output logic         valido,
  output logic [1:0]   estado
`ifdef SECUENCIADOR_VALIDA_CODIGO_EN
  ,
  output logic         error_codigo
`endif
);

  logic    pulso;
  estado_t estado_q;

  detector_flanco u_detector_cargar (
    .clk   (clk),
    .rst   (rst),
    .boton (cargar),
    .pulso (pulso)
  );

  assign estado = estado_q;

  // Load sequencer: clear has priority, otherwise each pulse stores entrada into the current slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= CARGA_A;
      operador1    <= '0;
      operador2    <= '0;
      ALUControl   <= 3'd0;
      valido       <= 1'b0;
`ifdef SECUENCIADOR_VALIDA_CODIGO_EN
      error_codigo <= 1'b0;
`endif
    end else begin
`ifdef SECUENCIADOR_VALIDA_CODIGO_EN
      error_codigo <= 1'b0;
`endif
      if (limpiar) begin
        // A pulse arriving together with the clear is intentionally dropped
        estado_q   <= CARGA_A;
        operador1  <= '0;
        operador2  <= '0;
        ALUControl <= 3'd0;
        valido     <= 1'b0;
      end else if (pulso) begin
        case (estado_q)
          CARGA_A: begin
            operador1 <= entrada;
            estado_q  <= CARGA_B;
          end
          CARGA_B: begin
            operador2 <= entrada;
            estado_q  <= CARGA_OP;
          end
          CARGA_OP: begin
`ifdef SECUENCIADOR_VALIDA_CODIGO_EN
            if (entrada[2:0] > CODIGO_MAX) begin
              // Undefined code: keep waiting for a valid one and flag it for one cycle
              error_codigo <= 1'b1;
            end else begin
              ALUControl <= entrada[2:0];
              valido     <= 1'b1;
              estado_q   <= LISTO;
            end
`else
            ALUControl <= entrada[2:0];
            valido     <= 1'b1;
            estado_q   <= LISTO;
`endif
          end
          LISTO: begin
            // New set begins; operand 2 and the op code stay until overwritten
            operador1 <= entrada;
            valido    <= 1'b0;
            estado_q  <= CARGA_B;
          end
          default: begin
            estado_q <= CARGA_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_operandos.sv
module tb_secuenciador_operandos;

  logic       clk;
  logic       rst;
  logic [7:0] entrada;
  logic       cargar;
  logic       limpiar;
  logic [7:0] operador1;
  logic [7:0] operador2;
  logic [2:0] ALUControl;
  logic       valido;
  logic [1:0] estado;

  int errores;
  int comprobaciones;

  // Reference model: which slot the next press fills, plus the values held
  int         m_paso;
  logic [7:0] m_op1;
  logic [7:0] m_op2;
  logic [2:0] m_alu;
  logic       m_val;

  secuenciador_operandos #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .entrada    (entrada),
    .cargar     (cargar),
    .limpiar    (limpiar),
    .operador1  (operador1),
    .operador2  (operador2),
    .ALUControl (ALUControl),
    .valido     (valido),
    .estado     (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    comprobaciones++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelo_limpio();
    m_paso = 0;
    m_op1  = 8'h00;
    m_op2  = 8'h00;
    m_alu  = 3'd0;
    m_val  = 1'b0;
  endtask

  // One load event: slots fill A, B, OP in order; after a full set the next press restarts at A
  task automatic modelo_carga(input logic [7:0] d);
    case (m_paso)
      0: begin m_op1 = d; m_paso = 1; end
      1: begin m_op2 = d; m_paso = 2; end
      2: begin m_alu = d[2:0]; m_val = 1'b1; m_paso = 3; end
      default: begin m_op1 = d; m_val = 1'b0; m_paso = 1; end
    endcase
  endtask

  task automatic comprobar_todo(input string tag);
    comprobar({tag, ".op1"}, {24'd0, operador1}, {24'd0, m_op1});
    comprobar({tag, ".op2"}, {24'd0, operador2}, {24'd0, m_op2});
    comprobar({tag, ".alu"}, {29'd0, ALUControl}, {29'd0, m_alu});
    comprobar({tag, ".val"}, {31'd0, valido}, {31'd0, m_val});
    comprobar({tag, ".est"}, m_paso, {30'd0, estado});
  endtask

  // Press starting just after an edge; capture expected on the third edge, then hold and release
  task automatic pulsar(input logic [7:0] d, input int hold, input string tag);
    entrada = d;
    cargar  = 1'b1;
    tick();
    tick();
    comprobar({tag, ".lat_e2"}, {30'd0, estado}, m_paso);
    comprobar({tag, ".lat_op1"}, {24'd0, operador1}, {24'd0, m_op1});
    tick();
    modelo_carga(d);
    comprobar_todo(tag);
    repeat (hold) tick();
    comprobar({tag, ".hold"}, {30'd0, estado}, m_paso);
    cargar = 1'b0;
    tick();
    tick();
    entrada = 8'h00;
  endtask

  task automatic pulsar_limpiar(input string tag);
    limpiar = 1'b1;
    tick();
    limpiar = 1'b0;
    modelo_limpio();
    comprobar_todo(tag);
  endtask

  initial begin
    errores        = 0;
    comprobaciones = 0;
    rst     = 1'b1;
    entrada = 8'h00;
    cargar  = 1'b0;
    limpiar = 1'b0;
    modelo_limpio();
    #12;
    comprobar_todo("reset");
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    // Full set A5, 3C, 02
    pulsar(8'hA5, 0, "carga_a");
    pulsar(8'h3C, 0, "carga_b");
    pulsar(8'h02, 0, "carga_op");
    comprobar("listo.val", {31'd0, valido}, 32'd1);
    comprobar("listo.est", {30'd0, estado}, 32'd3);

    // New set from LISTO keeps operand 2
    pulsar(8'h0F, 0, "reinicio");
    comprobar("reinicio.op2", {24'd0, operador2}, 32'h3C);

    // Clear on the same edge the pulse would write operand 2
    entrada = 8'h77;
    cargar  = 1'b1;
    tick();
    tick();
    limpiar = 1'b1;
    tick();
    limpiar = 1'b0;
    modelo_limpio();
    comprobar_todo("limpiar_vs_pulso");
    cargar = 1'b0;
    repeat (4) tick();
    comprobar_todo("limpiar_despues");

    // Long hold produces exactly one capture
    pulsar(8'h11, 20, "mantener");

    // Asynchronous reset in CARGA_OP, checked before the next edge
    pulsar(8'h22, 0, "pre_rst");
    comprobar("pre_rst.est", {30'd0, estado}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    modelo_limpio();
    comprobar_todo("rst_async");
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    pulsar(8'h5A, 0, "tras_rst");

    // Random sequences of presses and occasional clears
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulsar_limpiar("rnd_limpiar");
      end else begin
        pulsar(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errores, comprobaciones);
    $finish;
  end

endmodule

// File: doc/secuenciador_operandos.md
Name: secuenciador_operandos

Overview:
Upstream operand-loading stage for the logic unit. Captures operand 1, operand 2 and the 3-bit operation code, in that order, from one shared N-bit input bus (board switches), one value per load-button press. Holds the captured values as stable registered outputs that drive the logic unit's operand and ALUControl inputs. Raises a valid flag once all three values are loaded.

Parameters:
N, 8, operand width in bits; must match the logic unit's N; N >= 3

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
entrada  input  N  shared data bus (switches); sampled only on a load event; must be stable during the press
cargar  input  1  asynchronous load button, already debounced; rising edge = one load event
limpiar  input  1  synchronous clear; returns the FSM to the first load step
operador1  output  N  registered operand 1 to the logic unit
operador2  output  N  registered operand 2 to the logic unit
ALUControl  output  3  registered op code: 0 AND, 1 OR, 2 XOR, 3 NOT(op1), 4 shift-left, 5 shift-right
valido  output  1  high while all three values are loaded and held
estado  output  2  current FSM state, for LEDs/debug (encoding below)

Behaviour:
- Synchroniser: cargar passes through three flops s1->s2->s3; pulso = s2 & ~s3 (one clk wide).
- Latency: cargar rises before edge e1 -> pulso high between e2 and e3 -> register written at e3.
- entrada is sampled unsynchronised at the capturing edge.
- Holding cargar high gives exactly one event; a new event needs cargar low for >= 1 sampled cycle.
- FSM states and estado encoding: CARGA_A=0, CARGA_B=1, CARGA_OP=2, LISTO=3.
- CARGA_A + pulso: operador1 <= entrada; next state CARGA_B.
- CARGA_B + pulso: operador2 <= entrada; next state CARGA_OP.
- CARGA_OP + pulso: ALUControl <= entrada[2:0]; valido <= 1; next state LISTO. Upper bits of entrada are ignored.
- LISTO + pulso: starts a new set. operador1 <= entrada; valido <= 0; next state CARGA_B. operador2 and ALUControl keep their old values until overwritten.
- No pulso: every register holds; state holds.
- limpiar high at an edge: state <= CARGA_A; operador1, operador2, ALUControl <= 0; valido <= 0. Synchroniser flops are not cleared.
- limpiar has priority over a simultaneous pulso; that pulso is discarded.
- Reset values: state CARGA_A; operador1=0, operador2=0, ALUControl=0, valido=0, estado=0; s1, s2, s3 = 0.
- Reset asserted mid-sequence forces these values immediately, with no clock needed.
- Reset deassertion with cargar already high: s3 is 0, so one event is generated after the synchroniser delay. This is intended.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

Optional Feature:
Macro SECUENCIADOR_VALIDA_CODIGO_EN.
- Defined, in CARGA_OP: if entrada[2:0] > 5 the value is rejected. ALUControl is unchanged, state stays CARGA_OP, valido stays 0, and the one-cycle output error_codigo pulses high on the clock after the rejecting edge.
- error_codigo (output, 1 bit, reset 0) exists only when the macro is defined.
- Not defined: any 3-bit code is accepted; the logic unit decides what codes 6 and 7 produce.

Decomposition:
- Shared package alu_pkg: enum of FSM states (2-bit, values above) and enum of op codes (AND..SHR = 0..5).
- Also in alu_pkg: localparam CODIGO_MAX = 5, referenced by the validation check.
- One natural sub-module: detector_flanco (3-flop synchroniser + rising-edge pulse, async active-high reset). It is reusable for other board buttons.

Test Plan:
- Reset, then three presses with entrada=8'hA5, 8'h3C, 8'h02 -> operador1=A5, operador2=3C, ALUControl=2, valido=1, estado=3; first capture exactly 3 edges after cargar rises.
- cargar held high 20 cycles in CARGA_A -> exactly one capture; estado goes 0->1 once.
- In LISTO, press with entrada=8'h0F -> operador1=0F, valido=0, estado=1, operador2 still 3C.
- Assert limpiar on the same cycle pulso is high in CARGA_B -> estado=0, all outputs 0, operador2 not written.
- Assert rst asynchronously between clock edges in CARGA_OP -> outputs 0 before the next edge; sequence restarts from CARGA_A.
- With SECUENCIADOR_VALIDA_CODIGO_EN defined, entrada=8'h07 in CARGA_OP -> error_codigo pulses 1 cycle, estado stays 2, valido=0; next press with 8'h04 -> ALUControl=4, valido=1.
